// File: rtl/adc_limit_monitor_pkg.sv
// adc_limit_monitor_pkg: ADC/internal scaling constants shared with the DAC
// clamp, and the monitor FSM encoding (mirrored in the status register map).
package adc_limit_monitor_pkg;

    // The DAC clamp drops the two LSBs of the internal word (arithmetic >>2);
    // the monitor restores the scale by left-shifting the ADC word by
    // OUT_W - ADC_W.
    localparam int ADC_W = 14;
    localparam int OUT_W = 16;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_TRIPPED  = 2'd2,
        ST_HOLDOFF  = 2'd3
    } mon_state_e;

endpackage

// File: rtl/adc_limit_monitor_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; clr has priority but a
// coincident inc leaves the count at 1 so the event is not lost.
// Ports: clk, aresetn, inc, clr, count[WIDTH].
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? ONE : '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/adc_limit_monitor.sv
// adc_limit_monitor: rescales signed ADC samples to the internal format,
// checks them against signed limits and debounces violations into a trip.
// Ports: clk, aresetn, adc_in/adc_valid, limit_upper/limit_lower, enable,
// clear -> sample_out/sample_valid, over_upper, under_lower, trip,
// trip_count, state_out.
import adc_limit_monitor_pkg::*;

module adc_limit_monitor #(
    parameter int ADC_WIDTH      = ADC_W,
    parameter int OUT_WIDTH      = OUT_W,
    parameter int CNT_WIDTH      = 32,
    parameter int DEBOUNCE       = 4,
    parameter int HOLDOFF_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic [ADC_WIDTH-1:0] adc_in,
    input  logic                 adc_valid,
    input  logic [OUT_WIDTH-1:0] limit_upper,
    input  logic [OUT_WIDTH-1:0] limit_lower,
    input  logic                 enable,
    input  logic                 clear,
    output logic [OUT_WIDTH-1:0] sample_out,
    output logic                 sample_valid,
    output logic                 over_upper,
    output logic                 under_lower,
    output logic                 trip,
    output logic [CNT_WIDTH-1:0] trip_count,
    output logic [1:0]           state_out
);

    localparam int SHIFT  = OUT_WIDTH - ADC_WIDTH;
    localparam int RUN_W  = $clog2(DEBOUNCE + 1);
    localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(DEBOUNCE - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

    mon_state_e        state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              over_d, under_d;
    logic              viol_hi, viol_lo, viol;
    logic              trip_inc;

    // Stage 1: rescale, independent of enable.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_out   <= {adc_in, {SHIFT{1'b0}}};
            sample_valid <= adc_valid;
        end
    end

    assign viol_hi = sample_valid
                  && ($signed(sample_out) > $signed(limit_upper));
    assign viol_lo = sample_valid
                  && ($signed(sample_out) < $signed(limit_lower));
    assign viol    = viol_hi || viol_lo;

    // Stage 2: FSM, run/holdoff counters and sticky flags.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_DISABLED;
            run_q       <= '0;
            hold_q      <= '0;
            over_upper  <= 1'b0;
            under_lower <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            hold_q      <= hold_d;
            over_upper  <= over_d;
            under_lower <= under_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        hold_d   = hold_q;
        trip_inc = 1'b0;

        // A new violation wins over a coincident clear.
        over_d  = (over_upper && !clear)
               || (viol_hi && (state_q != ST_DISABLED));
        under_d = (under_lower && !clear)
               || (viol_lo && (state_q != ST_DISABLED));

        unique case (state_q)
            ST_DISABLED: begin
                if (enable) begin
                    state_d = ST_ARMED;
                    run_d   = '0;
                end
            end
            ST_ARMED: begin
                if (sample_valid) begin
                    if (!viol) begin
                        run_d = '0;
                    end else if (run_q == RUN_LAST) begin
                        state_d  = ST_TRIPPED;
                        run_d    = '0;
                        trip_inc = 1'b1;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
            end
            ST_TRIPPED: begin
                if (clear) begin
                    state_d = ST_HOLDOFF;
                    hold_d  = '0;
                end
            end
            ST_HOLDOFF: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_ARMED;
                    run_d   = '0;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
        endcase

        // Disabling overrides everything except the flags and the count.
        if (!enable) begin
            state_d  = ST_DISABLED;
            run_d    = '0;
            hold_d   = '0;
            trip_inc = 1'b0;
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_trip_cnt (
        .clk     (clk),
        .aresetn (aresetn),
        .inc     (trip_inc),
        .clr     (clear),
        .count   (trip_count)
    );

    assign trip      = (state_q == ST_TRIPPED);
    assign state_out = state_q;

endmodule
